// File: rtl/triplet_serializer.sv
// triplet_serializer: captures one x/y/z byte triplet per handshake and
// replays it as a four-beat stream (x, y, z, xor check) under valid/ready,
// counting every frame whose check byte is accepted.
module triplet_serializer #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W-1:0]     i_x,
    input  logic [W-1:0]     i_y,
    input  logic [W-1:0]     i_z,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_last,
    output logic [CNT_W-1:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SX   = 3'd1,
        SY   = 3'd2,
        SZ   = 3'd3,
        SCK  = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    logic [W-1:0] hx, hy, hz, ck;
    logic [W-1:0] hx_nx, hy_nx, hz_nx, ck_nx;
    logic [W-1:0] data_nx;
    logic         valid_nx;
    logic         last_nx;
    logic         ready_nx;
    logic [CNT_W-1:0] cnt_nx;

    logic capture;
    logic transfer;

    // o_ready is low right after reset, so no capture can happen on that edge
    assign capture  = (state == IDLE) && o_ready && i_valid;
    assign transfer = o_valid && i_ready;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: capture leaves IDLE, each transfer advances one beat
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (capture)  state_nx = SX;
            SX:      if (transfer) state_nx = SY;
            SY:      if (transfer) state_nx = SZ;
            SZ:      if (transfer) state_nx = SCK;
            SCK:     if (transfer) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs, derived from the
    // next state so each beat appears on the cycle its state is entered
    always_comb begin
        hx_nx = hx;
        hy_nx = hy;
        hz_nx = hz;
        ck_nx = ck;
        if (capture) begin
            hx_nx = i_x;
            hy_nx = i_y;
            hz_nx = i_z;
            ck_nx = i_x ^ i_y ^ i_z;
        end

        data_nx  = '0;
        valid_nx = 1'b0;
        last_nx  = 1'b0;
        ready_nx = 1'b0;
        case (state_nx)
            IDLE: ready_nx = 1'b1;
            SX: begin
                data_nx  = hx_nx;
                valid_nx = 1'b1;
            end
            SY: begin
                data_nx  = hy_nx;
                valid_nx = 1'b1;
            end
            SZ: begin
                data_nx  = hz_nx;
                valid_nx = 1'b1;
            end
            SCK: begin
                data_nx  = ck_nx;
                valid_nx = 1'b1;
                last_nx  = 1'b1;
            end
            default: ready_nx = 1'b0;
        endcase

        cnt_nx = o_frame_cnt;
        if ((state == SCK) && transfer) begin
            cnt_nx = o_frame_cnt + CNT_W'(1);
        end
    end

    // Hold registers and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hx          <= '0;
            hy          <= '0;
            hz          <= '0;
            ck          <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_last      <= 1'b0;
            o_ready     <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            hx          <= hx_nx;
            hy          <= hy_nx;
            hz          <= hz_nx;
            ck          <= ck_nx;
            o_data      <= data_nx;
            o_valid     <= valid_nx;
            o_last      <= last_nx;
            o_ready     <= ready_nx;
            o_frame_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_triplet_serializer.sv
// Directed self-checking bench for triplet_serializer.
module tb_triplet_serializer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_x = '0;
    logic [7:0] i_y = '0;
    logic [7:0] i_z = '0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b1;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic [7:0] o_frame_cnt;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt = '0;

    triplet_serializer #(.W(8), .CNT_W(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_z         (i_z),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Called at a sample point; asserts reset mid-cycle and releases it mid-cycle
    task automatic do_reset();
        #2 i_rst = 1'b1;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_last", o_last, 0);
        check("rst_ready", o_ready, 0);
        check("rst_cnt", o_frame_cnt, 0);
        step();
        check("rst_hold_ready", o_ready, 0);
        #2 i_rst = 1'b0;
        #1;
        check("rel_ready_before_edge", o_ready, 0);
        step();
        check("rel_ready_first_edge", o_ready, 1);
        check("rel_valid", o_valid, 0);
        exp_cnt = '0;
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                              input int stall_y, input int stall_ck,
                              input bit scramble, input int exp_cycles);
        logic [7:0] beat [4];
        int cycles;
        int s;
        int guard;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        if (o_ready !== 1'b1) check("ready_timeout", o_ready, 1);
        i_x = x; i_y = y; i_z = z;
        i_valid = 1'b1;
        i_ready = 1'b1;
        step();
        if (!scramble) i_valid = 1'b0;
        beat[0] = x; beat[1] = y; beat[2] = z; beat[3] = x ^ y ^ z;
        cycles = 0;
        for (int b = 0; b < 4; b++) begin
            s = (b == 1) ? stall_y : (b == 3) ? stall_ck : 0;
            for (int k = 0; k <= s; k++) begin
                i_ready = (k == s);
                if (scramble) begin
                    i_x = 8'($urandom); i_y = 8'($urandom); i_z = 8'($urandom);
                end
                check("beat_valid", o_valid, 1);
                check("beat_data", o_data, beat[b]);
                check("beat_last", o_last, (b == 3) ? 1 : 0);
                check("beat_ready", o_ready, 0);
                check("beat_cnt", o_frame_cnt, exp_cnt);
                step();
                cycles++;
            end
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        check("frame_cycles", cycles, exp_cycles);
        check("end_valid", o_valid, 0);
        check("end_last", o_last, 0);
        check("end_data", o_data, 0);
        check("end_ready", o_ready, 1);
        check("end_cnt", o_frame_cnt, exp_cnt);
    endtask

    initial begin
        do_reset();

        // Single frame, no stall: FF 00 FF 00
        send_frame(8'hFF, 8'h00, 8'hFF, 0, 0, 1'b0, 4);
        check("single_cnt", o_frame_cnt, 1);

        // Back-pressure: 3 stalls on y, 2 on ck; check byte 70
        send_frame(8'h12, 8'h34, 8'h56, 3, 2, 1'b0, 9);

        // Input isolation: lanes churn with i_valid high during the frame
        send_frame(8'h5A, 8'hC3, 8'h3C, 1, 0, 1'b1, 5);
        send_frame(8'h01, 8'h02, 8'h04, 0, 0, 1'b0, 4);

        // Reset during beat z of frame 3
        do_reset();
        send_frame(8'h10, 8'h20, 8'h40, 0, 0, 1'b0, 4);
        send_frame(8'h81, 8'h42, 8'h24, 0, 0, 1'b0, 4);
        i_x = 8'h11; i_y = 8'h22; i_z = 8'h33; i_valid = 1'b1; i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        check("abort_x", o_data, 8'h11);
        step();
        check("abort_y", o_data, 8'h22);
        step();
        check("abort_z", o_data, 8'h33);
        check("abort_cnt_before", o_frame_cnt, 2);
        do_reset();
        send_frame(8'hAA, 8'h55, 8'h0F, 0, 0, 1'b0, 4);
        check("after_abort_cnt", o_frame_cnt, 1);

        // Counter wrap over 257 back-to-back frames
        do_reset();
        for (int i = 1; i <= 257; i++) begin
            send_frame(8'(i), 8'(i * 3), 8'(i * 7), 0, 0, 1'b0, 4);
            if (i == 255) check("wrap_255", o_frame_cnt, 255);
            if (i == 256) check("wrap_0", o_frame_cnt, 0);
            if (i == 257) check("wrap_1", o_frame_cnt, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/triplet_serializer.md
# triplet_serializer

Downstream consumer of the three-lane byte source (`p_x`/`p_y`/`p_z` → `o_a`/`o_b`/`o_c`). It captures one 8-bit triplet per handshake. It then emits the triplet as a 4-beat byte stream: x, y, z, then an XOR check byte. Output uses valid/ready flow control, and the block counts completed frames. It sits between the lane-producing module and any narrow byte sink: a debug port, FIFO or monitor.

## Interface
- `W`, default 8: lane and output byte width; the check byte is also `W` bits.
- `CNT_W`, default 8: width of the completed-frame counter.
- `i_clk`  in  1  single clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_x`  in  W  lane x, sampled only at capture.
- `i_y`  in  W  lane y, sampled only at capture.
- `i_z`  in  W  lane z, sampled only at capture.
- `i_valid`  in  1  triplet on `i_x`/`i_y`/`i_z` is valid.
- `o_ready`  out  1  block can capture a triplet this cycle.
- `o_data`  out  W  current output byte.
- `o_valid`  out  1  `o_data` is valid.
- `i_ready`  in  1  sink accepts `o_data` this cycle.
- `o_last`  out  1  current beat is the check byte, i.e. the final beat of the frame.
- `o_frame_cnt`  out  CNT_W  number of fully accepted frames, modulo 2^CNT_W.

## Operation
- The FSM has five states: IDLE, SX, SY, SZ, SCK. All outputs are registered.
- **Capture.** Capture occurs in IDLE when `o_ready` and `i_valid` are both high.
  - Latch `i_x`, `i_y`, `i_z` into hold registers hx, hy, hz.
  - Latch ck = `i_x ^ i_y ^ i_z`.
  - Go to SX.
- **Beat sequence.**
  - SX drives `o_data`=hx.
  - SY drives hy.
  - SZ drives hz.
  - SCK drives ck with `o_last`=1.
  - `o_valid`=1 in all four states.
- **Advance rule.** Each state advances only on a cycle where `o_valid` and `i_ready` are both high (transfer). Without `i_ready`, `o_data`, `o_valid` and `o_last` hold exactly.
- **Frame completion.** A transfer in SCK does three things:
  - increments `o_frame_cnt`, wrapping from 2^CNT_W−1 to 0;
  - returns the FSM to IDLE;
  - drives `o_valid`=0 and `o_last`=0 on the next cycle.
- **`o_ready`.** It is 1 only in IDLE and 0 in SX..SCK.
  - `i_valid` outside IDLE is ignored; nothing is queued.
  - Input changes after capture do not affect the frame in flight.
- **`i_valid` in IDLE without `o_ready`.** This is impossible once out of reset. In IDLE, `o_ready`=1 from the cycle after reset release onward.
- **Reset mid-frame.** Asserting `i_rst` in any state aborts the frame immediately.
  - Outputs go to their reset values.
  - `o_frame_cnt` clears to 0.
  - No partial frame is resumed.
- **Output values outside SX..SCK.** When `o_valid`=0, `o_data` is 0.

## Timing
- **Reset values** (asynchronous, while `i_rst`=1): state=IDLE, `o_ready`=0, `o_valid`=0, `o_data`=0, `o_last`=0, `o_frame_cnt`=0, hold registers 0.
- **First edge after reset deassert:** `o_ready` becomes 1.
- **Capture latency:** capture occurs at edge N. `o_valid`=1 with `o_data`=hx is visible after edge N, with `o_ready`=0 in the same cycle.
- **With `i_ready` held 1:**
  - beats x, y, z, ck occupy cycles N+1 to N+4;
  - `o_ready` returns to 1 after edge N+4;
  - the next capture is possible at edge N+5.
  - Minimum period is therefore 5 cycles per frame.
- **Counter update:** `o_frame_cnt` updates on the same edge as the SCK transfer. The new value is visible in the cycle after `o_last` drops.
- **Back-pressure:** each stall cycle extends the frame by exactly one cycle. Data is never dropped or duplicated.

## Test plan
- **Reset behaviour:** assert `i_rst` asynchronously mid-cycle.
  - All outputs are 0 immediately.
  - After release, `o_ready`=1 on the first edge.
- **Single frame, no stall:** x=8'hFF, y=8'h00, z=8'hFF, `i_ready`=1.
  - Beats are FF, 00, FF, 00.
  - `o_last` is high only on beat 4.
  - `o_frame_cnt` goes 0→1.
  - Total of 5 cycles from capture to `o_ready` high again.
- **Back-pressure:** x=8'h12, y=8'h34, z=8'h56, with `i_ready` low for 3 cycles during beat y and 2 cycles during beat ck.
  - Beats are 12, 34, 56, 70.
  - `o_data` is stable throughout each stall.
  - Frame takes 9 cycles.
- **Input isolation:** change `i_x`/`i_y`/`i_z` and hold `i_valid`=1 during the frame.
  - The emitted frame matches the captured values.
  - A second capture occurs only in IDLE.
- **Counter wrap:** with CNT_W=8, run 257 back-to-back frames. `o_frame_cnt` reads 255, then 0, then 1.
- **Reset mid-frame:** assert `i_rst` during beat z of frame 3.
  - Outputs and counter go to 0.
  - The next frame, AA/55/0F, emits AA, 55, 0F, F0 cleanly.
